// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding, MDU latency default and register-zero helper
package pipe_hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MDU_WAIT, FETCH_WAIT} state_t;
    localparam int MDU_LAT_DEF = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    function automatic logic reg_hit(input logic [4:0] w, input logic [4:0] r);
        return (w != REG_ZERO) && (w == r);
    endfunction
endpackage

// File: rtl/pipe_mdu_timer.sv
// pipe_mdu_timer: loads LAT-1 on issue and counts down to zero
module pipe_mdu_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LAT = MDU_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);
    localparam int CW = $clog2(LAT);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= CW'(LAT - 1);
        else if (cnt != '0) cnt <= cnt - CW'(1);
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for F and D registers (load-use, branch, MDU, fetch wait)
// Optional PIPE_HAZARD_CTRL_PERF_EN adds stall_cycles / flush_count counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        branchD,
    input  logic        jumpD,
    input  logic        pcsrcD,
    input  logic        mdu_useD,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        memtoregM,
    input  logic        mdu_startE,
    input  logic        imem_ready,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        stallf,
    output logic        stalld,
    output logic        flushd,
    output logic        flushe,
    output logic        mdu_busy
);
    state_t state, state_nx;
    logic cnt_zero, hitE, hitM, lwstall, brstall, mdustall, fwait, stall_any;

    pipe_mdu_timer #(.LAT(MDU_LAT)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (mdu_startE && state != MDU_WAIT),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else state <= state_nx;
    end

    // MDU issue wins over a fetch wait; a running MDU keeps counting regardless of imem_ready
    always_comb begin
        state_nx = state;
        case (state)
            RUN:        state_nx = mdu_startE ? MDU_WAIT : (!imem_ready ? FETCH_WAIT : RUN);
            MDU_WAIT:   state_nx = cnt_zero ? RUN : MDU_WAIT;
            FETCH_WAIT: state_nx = mdu_startE ? MDU_WAIT : (imem_ready ? RUN : FETCH_WAIT);
            default:    state_nx = RUN;
        endcase
    end

    assign hitE      = reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD);
    assign hitM      = reg_hit(writeregM, rsD) || reg_hit(writeregM, rtD);
    assign lwstall   = memtoregE && hitE;
    assign brstall   = branchD && ((regwriteE && hitE) || (memtoregM && hitM));
    assign mdustall  = mdu_useD && state == MDU_WAIT;
    assign fwait     = state == FETCH_WAIT || !imem_ready;
    assign stall_any = lwstall || brstall || mdustall;

    // Reset forces bubbles into both registers and releases the stalls
    assign stalld   = rst_n && stall_any;
    assign stallf   = rst_n && (stall_any || fwait);
    assign flushe   = !rst_n || stall_any;
    assign flushd   = !rst_n || (!stall_any && (pcsrcD || jumpD || fwait));
    assign mdu_busy = state == MDU_WAIT;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, stallf};
            flush_count  <= flush_count + {31'd0, flushd};
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks against a cycle-count reference model
module tb_pipe_hazard_ctrl;
    localparam int LAT = 4;
    logic clk = 0;
    logic rst_n;
    logic [4:0] rsD, rtD, writeregE, writeregM;
    logic branchD, jumpD, pcsrcD, mdu_useD, regwriteE, memtoregE, memtoregM, mdu_startE, imem_ready;
    logic stallf, stalld, flushd, flushe, mdu_busy;
    logic [4:0] outs;
    int pass_n = 0, total_n = 0;
    int cyc, mstart;
    bit fw;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
        .pcsrcD(pcsrcD), .mdu_useD(mdu_useD), .writeregE(writeregE), .writeregM(writeregM),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .mdu_startE(mdu_startE), .imem_ready(imem_ready),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;
    assign outs = {stallf, stalld, flushd, flushe, mdu_busy};

    // Model: MDU busy is a window of LAT cycles after the issue cycle; fw remembers a fetch wait
    function automatic bit hit(logic [4:0] w, logic [4:0] r);
        return w != 0 && w == r;
    endfunction

    function automatic bit busy_m();
        return cyc > mstart && cyc <= mstart + LAT;
    endfunction

    function automatic logic [4:0] model();
        bit lw, br, sd, fwt;
        lw  = memtoregE && (hit(writeregE, rsD) || hit(writeregE, rtD));
        br  = branchD && ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                          (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
        sd  = lw || br || (mdu_useD && busy_m());
        fwt = fw || !imem_ready;
        return {sd || fwt, sd, !sd && (pcsrcD || jumpD || fwt), sd, busy_m()};
    endfunction

    task automatic advance();
        bit st, fwn;
        st  = mdu_startE && !busy_m();
        fwn = !busy_m() && !st && !imem_ready;
        @(posedge clk);
        if (st) mstart = cyc;
        cyc++;
        fw = fwn;
        #1;
    endtask

    task automatic idle();
        {rsD, rtD, writeregE, writeregM} = '0;
        {branchD, jumpD, pcsrcD, mdu_useD, regwriteE, memtoregE, memtoregM, mdu_startE} = '0;
        imem_ready = 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1;
        cyc = 0;
        mstart = -100;
        fw = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        total_n++;
        if (outs !== 5'b00110) $display("FAIL reset outs got %b want 00110", outs);
        else pass_n++;
        release_reset();
    endtask

    task automatic test_load_use();
        idle();
        memtoregE = 1; writeregE = 2; rsD = 2;
        @(negedge clk);
        total_n++;
        if (outs !== model() || outs !== 5'b11010) $display("FAIL load_use got %b want %b", outs, model());
        else pass_n++;
        advance();
        idle(); rsD = 2;
        @(negedge clk);
        total_n++;
        if (outs !== 5'b00000) $display("FAIL load_use_after got %b want 00000", outs);
        else pass_n++;
        advance();
        memtoregE = 1; writeregE = 0; rsD = 0;
        @(negedge clk);
        total_n++;
        if (outs !== 5'b00000) $display("FAIL reg_zero got %b want 00000", outs);
        else pass_n++;
        advance();
    endtask

    task automatic test_branch();
        idle();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        @(negedge clk);
        total_n++;
        if (outs !== 5'b11010) $display("FAIL branch_alu got %b want 11010", outs);
        else pass_n++;
        advance();
        regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 3;
        @(negedge clk);
        total_n++;
        if (outs !== 5'b11010) $display("FAIL branch_load got %b want 11010", outs);
        else pass_n++;
        advance();
        memtoregM = 0; pcsrcD = 1;
        @(negedge clk);
        total_n++;
        if (outs !== 5'b00100) $display("FAIL branch_taken got %b want 00100", outs);
        else pass_n++;
        advance();
    endtask

    task automatic test_mdu();
        int n = 0;
        idle();
        mdu_startE = 1;
        @(negedge clk);
        total_n++;
        if (outs !== model()) $display("FAIL mdu_issue got %b want %b", outs, model());
        else pass_n++;
        advance();
        mdu_startE = 0; mdu_useD = 1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            total_n++;
            if (outs !== model()) $display("FAIL mdu_wait cyc%0d got %b want %b", i, outs, model());
            else pass_n++;
            n += int'(stalld);
            advance();
        end
        total_n++;
        if (n != LAT) $display("FAIL mdu_stall_len got %0d want %0d", n, LAT);
        else pass_n++;
    endtask

    task automatic test_fetch();
        idle();
        for (int i = 0; i < 5; i++) begin
            imem_ready = i >= 3;
            @(negedge clk);
            total_n++;
            if (outs !== model()) $display("FAIL fetch cyc%0d got %b want %b", i, outs, model());
            else pass_n++;
            advance();
        end
        idle();
        @(negedge clk);
        total_n++;
        if (outs !== 5'b00000) $display("FAIL fetch_done got %b want 00000", outs);
        else pass_n++;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            branchD = $urandom_range(0, 2) == 0; jumpD = $urandom_range(0, 7) == 0;
            pcsrcD = $urandom_range(0, 5) == 0; mdu_useD = $urandom_range(0, 1) == 1;
            regwriteE = $urandom_range(0, 1) == 1; memtoregE = $urandom_range(0, 3) == 0;
            memtoregM = $urandom_range(0, 3) == 0; mdu_startE = $urandom_range(0, 11) == 0;
            imem_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            total_n++;
            if (outs !== model()) $display("FAIL random cyc%0d got %b want %b", i, outs, model());
            else pass_n++;
            advance();
        end
    endtask

    task automatic test_reset_mid_mdu();
        idle();
        mdu_startE = 1;
        advance();
        mdu_startE = 0;
        advance();
        @(negedge clk);
        total_n++;
        if (mdu_busy !== 1'b1) $display("FAIL pre_reset_busy got %b want 1", mdu_busy);
        else pass_n++;
        rst_n = 0;
        #1;
        total_n++;
        if (outs !== 5'b00110) $display("FAIL reset_mid_mdu got %b want 00110", outs);
        else pass_n++;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total_n++;
        if (stall_cycles !== 0 || flush_count !== 0)
            $display("FAIL perf_reset got %0d/%0d want 0/0", stall_cycles, flush_count);
        else pass_n++;
`endif
        release_reset();
        @(negedge clk);
        total_n++;
        if (outs !== 5'b00000) $display("FAIL post_reset got %b want 00000", outs);
        else pass_n++;
        advance();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_fetch();
        test_random();
        test_reset_mid_mdu();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
